mem_arbiter: RTL and testbench

- Shares one single-ported, variable-latency unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Grants one access at a time and drives the IF and MEM stall signals into the hazard logic, which OR's them into PC-keep and pipeline-keep.
- Discards in-flight fetches killed by branch/jump flushes.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/sat_counter.sv | 37 +++
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared constants for the unified-memory arbiter that sits between the
//   IF and MEM pipeline stages and the single-ported memory.
//
//   Contents:
//     - 2-bit arbiter state encodings (IDLE, DATA_BUSY, INST_BUSY,
//       INST_DISCARD). These stay plain constants so older code that
//       compares raw state bits keeps working.
//     - STALL_CNT_WIDTH : width of the stall-cycle performance counter.
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] DATA_BUSY    = 2'd1;
    localparam logic [1:0] INST_BUSY    = 2'd2;
    localparam logic [1:0] INST_DISCARD = 2'd3;

    localparam int STALL_CNT_WIDTH = 32;

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter with enable. Counts once per enabled clock and
//   sticks at all-ones instead of wrapping, so a long run never reports a
//   deceptively small number.
//
//   Ports:
//     clk    : system clock
//     rst_n  : asynchronous active-low reset, clears the count
//     en     : count this cycle
//     count  : current count value (WIDTH bits)
// ----------------------------------------------------------------------------
module sat_counter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH = STALL_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    // Increment only while below the all-ones ceiling; once there, hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (en && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-ported, variable-latency unified memory between the
//   IF stage (instruction fetch) and the MEM stage (load/store). One access
//   is in flight at a time; data accesses win over fetches. Fetches that a
//   branch/jump flush makes stale are still completed on the memory side
//   (the memory cannot abort) but their data is dropped. Stall outputs feed
//   the hazard unit, and a saturating counter tracks stall cycles.
//
//   Ports:
//     clk, reset            : clock, asynchronous active-low reset
//     i_inst_req/addr       : IF stage fetch request and PC
//     i_flush               : IF/ID flush, the current fetch is stale
//     i_data_req/we/addr/
//       wdata               : MEM stage load (we=0) or store (we=1)
//     o_mem_req/we/addr/
//       wdata               : request to memory, held until i_mem_ack
//     i_mem_ack/rdata       : memory completion and read data
//     o_inst, o_inst_valid  : fetched instruction, one-cycle valid pulse
//     o_data_rdata,
//       o_data_done         : load result, one-cycle done pulse
//     o_if_stall            : hold PC and IF/ID
//     o_mem_stall           : hold the pipeline up to MEM
//     o_stall_cycles        : saturating count of stall cycles
// ----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       i_inst_req,
    input  logic [ADDR_WIDTH-1:0]      i_inst_addr,
    input  logic                       i_flush,

    input  logic                       i_data_req,
    input  logic                       i_data_we,
    input  logic [ADDR_WIDTH-1:0]      i_data_addr,
    input  logic [DATA_WIDTH-1:0]      i_data_wdata,

    output logic                       o_mem_req,
    output logic                       o_mem_we,
    output logic [ADDR_WIDTH-1:0]      o_mem_addr,
    output logic [DATA_WIDTH-1:0]      o_mem_wdata,
    input  logic                       i_mem_ack,
    input  logic [DATA_WIDTH-1:0]      i_mem_rdata,

    output logic [DATA_WIDTH-1:0]      o_inst,
    output logic                       o_inst_valid,
    output logic [DATA_WIDTH-1:0]      o_data_rdata,
    output logic                       o_data_done,

    output logic                       o_if_stall,
    output logic                       o_mem_stall,
    output logic [STALL_CNT_WIDTH-1:0] o_stall_cycles
);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic data_start;
    logic inst_start;
    logic if_stall_raw;
    logic mem_stall_raw;

    // The done/valid terms stop us re-issuing a request that the pipeline is
    // retiring on this very edge; the flush term avoids fetching a stale PC.
    assign data_start = i_data_req && !o_data_done;
    assign inst_start = i_inst_req && !o_inst_valid && !i_flush;

    // Arbiter FSM. Address/we/wdata are captured at grant time so the memory
    // sees stable values for the whole request, independent of the pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            o_inst       <= '0;
            o_inst_valid <= 1'b0;
            o_data_rdata <= '0;
            o_data_done  <= 1'b0;
        end else begin
            o_inst_valid <= 1'b0;
            o_data_done  <= 1'b0;

            case (state)
                IDLE: begin
                    if (data_start) begin
                        addr_q  <= i_data_addr;
                        we_q    <= i_data_we;
                        wdata_q <= i_data_wdata;
                        state   <= DATA_BUSY;
                    end else if (inst_start) begin
                        addr_q  <= i_inst_addr;
                        we_q    <= 1'b0;
                        state   <= INST_BUSY;
                    end
                end

                DATA_BUSY: begin
                    if (i_mem_ack) begin
                        o_data_done <= 1'b1;
                        if (!we_q) begin
                            o_data_rdata <= i_mem_rdata;
                        end
                        state <= IDLE;
                    end
                end

                // A flush arriving with the ack drops the word right away;
                // a flush before the ack parks us in INST_DISCARD until the
                // memory finishes the now-useless access.
                INST_BUSY: begin
                    if (i_mem_ack) begin
                        if (!i_flush) begin
                            o_inst       <= i_mem_rdata;
                            o_inst_valid <= 1'b1;
                        end
                        state <= IDLE;
                    end else if (i_flush) begin
                        state <= INST_DISCARD;
                    end
                end

                INST_DISCARD: begin
                    if (i_mem_ack) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign o_mem_req   = (state != IDLE);
    assign o_mem_we    = o_mem_req && we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;

    assign if_stall_raw  = i_inst_req && !o_inst_valid;
    assign mem_stall_raw = i_data_req && !o_data_done;

    // Outputs to the hazard unit are gated low during reset. The counter
    // takes the ungated terms: it is held in reset anyway, and this keeps the
    // reset net out of any flop's data path.
    assign o_if_stall  = reset && if_stall_raw;
    assign o_mem_stall = reset && mem_stall_raw;

    sat_counter #(
        .WIDTH (STALL_CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .en    (if_stall_raw || mem_stall_raw),
        .count (o_stall_cycles)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. A transaction-level model (one
//   outstanding access record plus result registers) predicts every output
//   and is compared each cycle; directed scenarios add hand-computed
//   literal checks. A small memory responder acks after a programmable
//   number of request cycles and returns words from a fixed image.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic        i_inst_req;
    logic [31:0] i_inst_addr;
    logic        i_flush;
    logic        i_data_req;
    logic        i_data_we;
    logic [31:0] i_data_addr;
    logic [31:0] i_data_wdata;
    logic        i_mem_ack   = 1'b0;
    logic [31:0] i_mem_rdata = 32'h0;

    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] o_inst;
    logic        o_inst_valid;
    logic [31:0] o_data_rdata;
    logic        o_data_done;
    logic        o_if_stall;
    logic        o_mem_stall;
    logic [31:0] o_stall_cycles;

    mem_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_inst_req     (i_inst_req),
        .i_inst_addr    (i_inst_addr),
        .i_flush        (i_flush),
        .i_data_req     (i_data_req),
        .i_data_we      (i_data_we),
        .i_data_addr    (i_data_addr),
        .i_data_wdata   (i_data_wdata),
        .o_mem_req      (o_mem_req),
        .o_mem_we       (o_mem_we),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .i_mem_ack      (i_mem_ack),
        .i_mem_rdata    (i_mem_rdata),
        .o_inst         (o_inst),
        .o_inst_valid   (o_inst_valid),
        .o_data_rdata   (o_data_rdata),
        .o_data_done    (o_data_done),
        .o_if_stall     (o_if_stall),
        .o_mem_stall    (o_mem_stall),
        .o_stall_cycles (o_stall_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic inst_req, input logic [31:0] inst_addr,
                                 input logic flush, input logic data_req,
                                 input logic data_we, input logic [31:0] data_addr,
                                 input logic [31:0] data_wdata);
        i_inst_req   = inst_req;
        i_inst_addr  = inst_addr;
        i_flush      = flush;
        i_data_req   = data_req;
        i_data_we    = data_we;
        i_data_addr  = data_addr;
        i_data_wdata = data_wdata;
    endtask

    task automatic waitPulse(input bit want_inst, input int budget, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (want_inst ? o_inst_valid : o_data_done) seen = 1'b1;
        end
    endtask

    // Memory image returned on read acks.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0010: mem_word = 32'h8C22_0004;
            32'h0000_0020: mem_word = 32'h00A4_2820;
            32'h0000_0080: mem_word = 32'h2402_000A;
            32'h0000_1000: mem_word = 32'h1234_5678;
            default:       mem_word = a ^ 32'hA5A5_5A5A;
        endcase
    endfunction

    // Memory responder: ack in the ack_lat-th cycle of a request. With
    // stray_ack set it also raises ack while no request is pending.
    int ack_lat   = 1;
    int req_cnt   = 0;
    bit stray_ack = 1'b0;

    always @(negedge clk) begin
        if (o_mem_req) begin
            req_cnt = req_cnt + 1;
            if (req_cnt == ack_lat) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = mem_word(o_mem_addr);
            end else begin
                i_mem_ack   = 1'b0;
                i_mem_rdata = 32'hFFFF_0000;
            end
        end else begin
            req_cnt     = 0;
            i_mem_ack   = stray_ack;
            i_mem_rdata = 32'h5555_AAAA;
        end
    end

    // Transaction-level model: at most one outstanding access record.
    bit          m_busy, m_is_inst, m_killed, m_we, m_inst_valid, m_done;
    logic [31:0] m_addr, m_wdata, m_inst, m_rdata, m_count;
    int          preload_seq  = 0;
    int          preload_seen = 0;

    always @(posedge clk or negedge reset) begin
        bit stall, nv, nd;
        if (!reset) begin
            m_busy = 0; m_is_inst = 0; m_killed = 0; m_we = 0;
            m_inst_valid = 0; m_done = 0;
            m_addr = 0; m_wdata = 0; m_inst = 0; m_rdata = 0; m_count = 0;
            preload_seen = preload_seq;
        end else begin
            stall = (i_inst_req && !m_inst_valid) || (i_data_req && !m_done);
            if (preload_seq != preload_seen) begin
                m_count      = 32'hFFFF_FFFE;
                preload_seen = preload_seq;
            end
            if (stall && m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
            nv = 0;
            nd = 0;
            if (m_busy) begin
                if (m_is_inst && i_flush) m_killed = 1;
                if (i_mem_ack) begin
                    m_busy = 0;
                    if (!m_is_inst) begin
                        nd = 1;
                        if (!m_we) m_rdata = i_mem_rdata;
                    end else if (!m_killed) begin
                        nv     = 1;
                        m_inst = i_mem_rdata;
                    end
                end
            end else if (i_data_req && !m_done) begin
                m_busy = 1; m_is_inst = 0; m_killed = 0;
                m_we = i_data_we; m_addr = i_data_addr; m_wdata = i_data_wdata;
            end else if (i_inst_req && !m_inst_valid && !i_flush) begin
                m_busy = 1; m_is_inst = 1; m_killed = 0;
                m_we = 0; m_addr = i_inst_addr;
            end
            m_inst_valid = nv;
            m_done       = nd;
        end
    end

    // Per-cycle comparison against the model, 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        checkOutput("cyc_mem_req", 32'(o_mem_req), 32'(m_busy));
        checkOutput("cyc_mem_we", 32'(o_mem_we), 32'(m_busy && m_we));
        if (m_busy) checkOutput("cyc_mem_addr", o_mem_addr, m_addr);
        if (m_busy && m_we) checkOutput("cyc_mem_wdata", o_mem_wdata, m_wdata);
        checkOutput("cyc_inst_valid", 32'(o_inst_valid), 32'(m_inst_valid));
        checkOutput("cyc_inst", o_inst, m_inst);
        checkOutput("cyc_data_done", 32'(o_data_done), 32'(m_done));
        checkOutput("cyc_data_rdata", o_data_rdata, m_rdata);
        checkOutput("cyc_if_stall", 32'(o_if_stall),
                    32'(reset && i_inst_req && !m_inst_valid));
        checkOutput("cyc_mem_stall", 32'(o_mem_stall),
                    32'(reset && i_data_req && !m_done));
        checkOutput("cyc_stall_cycles", o_stall_cycles, m_count);
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit got, stall_ok, new_seen, gap_seen;
        int req_cycles, lat_cycles, old_cycles;

        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        checkOutput("rst_mem_req", 32'(o_mem_req), 32'd0);
        checkOutput("rst_inst_valid", 32'(o_inst_valid), 32'd0);
        checkOutput("rst_stall_cycles", o_stall_cycles, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Single fetch, ack in the 2nd request cycle.
        $display("[TB] single fetch");
        ack_lat = 2;
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        got = 0; req_cycles = 0; stall_ok = 1; lat_cycles = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (o_inst_valid) begin
                got = 1;
                lat_cycles = c;
                checkOutput("t2_inst", o_inst, 32'h8C22_0004);
            end else begin
                if (!o_if_stall) stall_ok = 0;
                if (o_mem_req) begin
                    req_cycles++;
                    checkOutput("t2_mem_addr", o_mem_addr, 32'h10);
                end
            end
        end
        checkOutput("t2_valid_seen", 32'(got), 32'd1);
        checkOutput("t2_req_cycles", 32'(req_cycles), 32'd2);
        checkOutput("t2_pulse_cycle", 32'(lat_cycles), 32'd2);
        checkOutput("t2_if_stall", 32'(stall_ok), 32'd1);
        @(negedge clk);
        checkOutput("t2_no_reissue", 32'(o_mem_req), 32'd0);
        checkOutput("t2_valid_one_cycle", 32'(o_inst_valid), 32'd0);
        i_inst_req = 1'b0;
        @(negedge clk);

        // Reset in the middle of a fetch, then stray acks while idle.
        $display("[TB] reset mid-access");
        ack_lat = 3;
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("t1_req_before_reset", 32'(o_mem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("t1_mem_req", 32'(o_mem_req), 32'd0);
        checkOutput("t1_mem_addr", o_mem_addr, 32'd0);
        checkOutput("t1_inst", o_inst, 32'd0);
        checkOutput("t1_if_stall", 32'(o_if_stall), 32'd0);
        checkOutput("t1_stall_cycles", o_stall_cycles, 32'd0);
        @(negedge clk);
        i_inst_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        stray_ack = 1'b1;
        got = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_inst_valid || o_data_done || o_mem_req) got = 1;
        end
        stray_ack = 1'b0;
        checkOutput("t1_quiet_after_reset", 32'(got), 32'd0);
        @(negedge clk);

        // Simultaneous fetch and load: data first, fetch after the done cycle.
        $display("[TB] simultaneous requests");
        ack_lat = 1;
        applyStimulus(1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h1000, 32'h0);
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (o_data_done) begin
                got = 1;
                checkOutput("t3_load_data", o_data_rdata, 32'h1234_5678);
                checkOutput("t3_no_fetch_in_done", 32'(o_mem_req), 32'd0);
            end else if (o_mem_req) begin
                checkOutput("t3_data_first_addr", o_mem_addr, 32'h1000);
            end
        end
        checkOutput("t3_done_seen", 32'(got), 32'd1);
        @(negedge clk);
        checkOutput("t3_fetch_req", 32'(o_mem_req), 32'd1);
        checkOutput("t3_fetch_addr", o_mem_addr, 32'h20);
        checkOutput("t3_fetch_we", 32'(o_mem_we), 32'd0);
        i_data_req = 1'b0;
        waitPulse(1'b1, 10, got);
        checkOutput("t3_inst_seen", 32'(got), 32'd1);
        checkOutput("t3_inst", o_inst, 32'h00A4_2820);
        @(negedge clk);
        i_inst_req = 1'b0;
        @(negedge clk);

        // Store: rdata must keep the previous load result.
        $display("[TB] store");
        ack_lat = 3;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h2004, 32'hDEAD_BEEF);
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (o_data_done) begin
                got = 1;
                checkOutput("t4_rdata_kept", o_data_rdata, 32'h1234_5678);
            end else if (o_mem_req) begin
                checkOutput("t4_mem_we", 32'(o_mem_we), 32'd1);
                checkOutput("t4_mem_addr", o_mem_addr, 32'h2004);
                checkOutput("t4_mem_wdata", o_mem_wdata, 32'hDEAD_BEEF);
            end
        end
        checkOutput("t4_done_seen", 32'(got), 32'd1);
        @(negedge clk);
        i_data_req = 1'b0;
        i_data_we  = 1'b0;
        @(negedge clk);

        // Flush in INST_BUSY, ack three cycles later; new PC waits for it.
        $display("[TB] flush during fetch");
        ack_lat = 4;
        applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("t5_req_started", 32'(o_mem_req), 32'd1);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush     = 1'b0;
        i_inst_addr = 32'h80;
        got = 0; new_seen = 0; gap_seen = 0; old_cycles = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (o_inst_valid) begin
                got = 1;
                checkOutput("t5_valid_only_for_new", 32'(new_seen), 32'd1);
                checkOutput("t5_new_inst", o_inst, 32'h2402_000A);
            end else if (o_mem_req) begin
                if (o_mem_addr == 32'h30) old_cycles++;
                else new_seen = 1;
            end else if (!new_seen) begin
                gap_seen = 1;
            end
        end
        checkOutput("t5_inst_seen", 32'(got), 32'd1);
        checkOutput("t5_stale_req_cycles", 32'(old_cycles), 32'd2);
        checkOutput("t5_idle_gap", 32'(gap_seen), 32'd1);

        // Variant: flush in the same cycle as the ack.
        $display("[TB] flush with ack");
        @(negedge clk);
        ack_lat     = 2;
        i_inst_addr = 32'h90;
        @(negedge clk);
        @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        checkOutput("t5v_no_valid", 32'(o_inst_valid), 32'd0);
        checkOutput("t5v_inst_kept", o_inst, 32'h2402_000A);
        checkOutput("t5v_idle", 32'(o_mem_req), 32'd0);
        i_flush    = 1'b0;
        i_inst_req = 1'b0;
        @(negedge clk);
        checkOutput("t5v_still_no_valid", 32'(o_inst_valid), 32'd0);
        @(negedge clk);

        // Counter saturation.
        $display("[TB] counter saturation");
        force dut.u_stall_cnt.count_q = 32'hFFFF_FFFE;
        preload_seq++;
        #1 release dut.u_stall_cnt.count_q;
        checkOutput("t6_preload", o_stall_cycles, 32'hFFFF_FFFE);
        ack_lat = 5;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h3000, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("t6_saturated", o_stall_cycles, 32'hFFFF_FFFF);
            checkOutput("t6_stalling", 32'(o_mem_stall), 32'd1);
        end
        waitPulse(1'b0, 10, got);
        checkOutput("t6_done_seen", 32'(got), 32'd1);
        checkOutput("t6_load_data", o_data_rdata, 32'hA5A5_6A5A);
        @(negedge clk);
        i_data_req = 1'b0;

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
